vppm_demod: RTL and testbench
=============================

VPPM_DEMOD -- requirements
Module: vppm_demod

Interface
REQ-001 The module SHALL have parameter SYM_LEN, default 16, giving sample ticks per VPPM symbol (even, 4..254).
REQ-002 The module SHALL have port clk, input, 1, system clock, with all state updated on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 The module SHALL have port clk_smp, input, 1, sample clock from the upstream astable divider, asynchronous to clk in phase.
REQ-005 The module SHALL have port rx_in, input, 1, photodetector comparator output, asynchronous.
REQ-006 The module SHALL have port data_out, output, 8, last completed byte, MSB first on the line.
REQ-007 The module SHALL have port data_valid, output, 1, one-clk pulse when data_out is updated.
REQ-008 The module SHALL have port duty, output, 8, high-sample count of the last completed symbol (dimming level).
REQ-009 The module SHALL have port locked, output, 1, high while the state machine is in ACTIVE.
REQ-010 The module SHALL have port sym_err, output, 1, one-clk pulse on an ambiguous symbol.
REQ-011 The module SHALL have port lost, output, 1, one-clk pulse on carrier loss.

Function
REQ-012 rx_in and clk_smp SHALL each pass through a 2-FF synchronizer on clk.
REQ-013 A tick SHALL be a one-clk pulse on each synchronized 0->1 transition of clk_smp, with exactly one tick per clk_smp period.
REQ-014 On each tick, the module SHALL capture the synchronized rx as the current sample and keep the previous sample.
REQ-015 The state machine SHALL have two states: IDLE and ACTIVE.
REQ-016 In IDLE, a tick with current sample 1 and previous sample 0 SHALL move to ACTIVE, set sample index idx=1, set hi_a=1 and hi_b=0, and set the start flag.
REQ-017 In ACTIVE, each tick SHALL add the sample to hi_a when idx < SYM_LEN/2, otherwise to hi_b.
REQ-018 In ACTIVE, idx SHALL increment on each tick and wrap to 0 after SYM_LEN-1.
REQ-019 A symbol end is the tick that takes sample idx=SYM_LEN-1; the decision SHALL include that sample.
REQ-020 At symbol end, the decoded bit SHALL be 1 if hi_b > hi_a and 0 otherwise.
REQ-021 At symbol end with hi_a == hi_b and total high count nonzero, the module SHALL pulse sym_err and treat the bit as 0.
REQ-022 At symbol end with hi_a+hi_b == 0, the module SHALL pulse lost, return to IDLE, clear the bit counter and shift register, leave data_out unchanged, and SHALL NOT shift a bit.
REQ-023 Otherwise at symbol end, duty SHALL load hi_a+hi_b, which saturates at 255.
REQ-024 Otherwise at symbol end, if the start flag is set it SHALL clear and no bit SHALL be shifted, since the first symbol is a start symbol encoding 0.
REQ-025 Otherwise at symbol end with the start flag clear, the bit SHALL shift into the LSB of the shift register and the bit counter SHALL increment.
REQ-026 When the bit counter reaches 8, data_out SHALL load the 8-bit shift value including the new bit, data_valid SHALL pulse one clk, and the counter SHALL reset to 0.
REQ-027 hi_a and hi_b SHALL clear to 0 after every symbol end.
REQ-028 All outputs SHALL be registered and SHALL change on the clk edge that consumes the symbol-end tick.
REQ-029 locked SHALL equal (state == ACTIVE).
REQ-030 rx activity between ticks SHALL be ignored.
REQ-031 A tick in IDLE without a rising sample edge SHALL leave all state except the previous sample unchanged.

Reset
REQ-032 While rst is high, the module SHALL force: state IDLE, idx, hi_a, hi_b, bit counter, shift register, and previous sample to 0, start flag clear, synchronizers to 0.
REQ-033 While rst is high, all outputs SHALL be 0: data_out=0x00, data_valid=0, duty=0, locked=0, sym_err=0, lost=0.
REQ-034 Reset asserted mid-symbol or mid-byte SHALL discard the partial symbol and byte, with no pulse on data_valid, sym_err, or lost.

Verification (SYM_LEN=16)
REQ-035 Start symbol high for idx 0-3, then byte 0xA5 with bit0 = high idx 0-3 and bit1 = high idx 12-15 -> locked rises at the first edge, one data_valid with data_out=0xA5, duty=4.
REQ-036 Dimming sweep with pulse widths 2, 6, 8 -> duty equals 2, 6, 8 respectively, and bits are decoded correctly.
REQ-037 Symbol high for idx 6-9 -> sym_err pulses once, a 0 is shifted, and locked stays 1.
REQ-038 rx held low for one full symbol after 5 bits -> lost pulses, locked=0, no data_valid; a following 8-bit frame decodes correctly.
REQ-039 rst asserted at idx 7 of the 4th bit -> all outputs are 0 immediately; after release, a new start symbol and byte 0x3C give data_out=0x3C.
REQ-040 clk_smp period swept at 10, 22, and 50 clk cycles -> exactly one tick per clk_smp period, and decode is identical in all three cases.

Source files
------------

// File: rtl/vppm_demod.sv
// VPPM receiver: synchronizes the sample clock and comparator input, recovers the
// symbol timing from the start-symbol edge, decodes one bit per symbol and reports dimming level.
`timescale 1ns/1ps
module vppm_demod #(
  parameter int SYM_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_smp,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [7:0] duty,
  output logic       locked,
  output logic       sym_err,
  output logic       lost
);
  localparam int IW = $clog2(SYM_LEN);
  localparam logic [IW-1:0] HALF = IW'(SYM_LEN / 2);
  localparam logic [IW-1:0] LAST = IW'(SYM_LEN - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic rx_meta_reg, rx_sync_reg;
  logic smp_meta_reg, smp_sync_reg, smp_prev_reg;
  logic tick;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [7:0]      hi_a_reg, hi_a_next;
  logic [7:0]      hi_b_reg, hi_b_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      sr_reg, sr_next;
  logic            prev_reg, prev_next;
  logic            start_reg, start_next;
  logic [7:0]      data_out_reg, data_out_next;
  logic [7:0]      duty_reg, duty_next;
  logic            valid_reg, valid_next;
  logic            err_reg, err_next;
  logic            lost_reg, lost_next;

  logic [7:0]      a_new, b_new;
  logic [8:0]      total;
  logic            bit_val;

  // Both inputs share the same synchronizer depth so a sample lines up with its tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg  <= 1'b0;
      rx_sync_reg  <= 1'b0;
      smp_meta_reg <= 1'b0;
      smp_sync_reg <= 1'b0;
      smp_prev_reg <= 1'b0;
    end else begin
      rx_meta_reg  <= rx_in;
      rx_sync_reg  <= rx_meta_reg;
      smp_meta_reg <= clk_smp;
      smp_sync_reg <= smp_meta_reg;
      smp_prev_reg <= smp_sync_reg;
    end
  end

  assign tick = smp_sync_reg & ~smp_prev_reg;

  // Running half-symbol counts including the sample taken on this tick.
  assign a_new   = (idx_reg < HALF)  ? hi_a_reg + {7'd0, rx_sync_reg} : hi_a_reg;
  assign b_new   = (idx_reg >= HALF) ? hi_b_reg + {7'd0, rx_sync_reg} : hi_b_reg;
  assign total   = {1'b0, a_new} + {1'b0, b_new};
  assign bit_val = (b_new > a_new);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      hi_a_reg     <= '0;
      hi_b_reg     <= '0;
      bit_cnt_reg  <= '0;
      sr_reg       <= '0;
      prev_reg     <= 1'b0;
      start_reg    <= 1'b0;
      data_out_reg <= '0;
      duty_reg     <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      lost_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      hi_a_reg     <= hi_a_next;
      hi_b_reg     <= hi_b_next;
      bit_cnt_reg  <= bit_cnt_next;
      sr_reg       <= sr_next;
      prev_reg     <= prev_next;
      start_reg    <= start_next;
      data_out_reg <= data_out_next;
      duty_reg     <= duty_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
      lost_reg     <= lost_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    hi_a_next     = hi_a_reg;
    hi_b_next     = hi_b_reg;
    bit_cnt_next  = bit_cnt_reg;
    sr_next       = sr_reg;
    prev_next     = prev_reg;
    start_next    = start_reg;
    data_out_next = data_out_reg;
    duty_next     = duty_reg;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    lost_next     = 1'b0;

    if (tick) begin
      prev_next = rx_sync_reg;
      if (state_reg == IDLE) begin
        if (rx_sync_reg && !prev_reg) begin
          state_next = ACTIVE;
          idx_next   = IW'(1);
          hi_a_next  = 8'd1;
          hi_b_next  = 8'd0;
          start_next = 1'b1;
        end
      end else if (idx_reg == LAST) begin
        idx_next  = '0;
        hi_a_next = '0;
        hi_b_next = '0;
        if (total == 9'd0) begin
          // An all-dark symbol means the carrier is gone; drop the partial byte.
          lost_next    = 1'b1;
          state_next   = IDLE;
          bit_cnt_next = '0;
          sr_next      = '0;
        end else begin
          duty_next = total[8] ? 8'hFF : total[7:0];
          err_next  = (a_new == b_new);
          if (start_reg) begin
            start_next = 1'b0;
          end else begin
            sr_next = {sr_reg[6:0], bit_val};
            if (bit_cnt_reg == 3'd7) begin
              data_out_next = {sr_reg[6:0], bit_val};
              valid_next    = 1'b1;
              bit_cnt_next  = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end
      end else begin
        idx_next  = idx_reg + IW'(1);
        hi_a_next = a_new;
        hi_b_next = b_new;
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = valid_reg;
  assign duty       = duty_reg;
  assign locked     = (state_reg == ACTIVE);
  assign sym_err    = err_reg;
  assign lost       = lost_reg;

endmodule

// File: tb/tb_vppm_demod.sv
// Bench for vppm_demod: builds a sample stream, predicts outputs per sample with a
// symbol-window model, checks every clk and pins key points with literal values.
`timescale 1ns/1ps
module tb_vppm_demod;
  localparam int SYM = 16;

  logic clk = 1'b0, rst = 1'b1, clk_smp = 1'b0, rx_in = 1'b0;
  logic [7:0] data_out, duty;
  logic data_valid, locked, sym_err, lost;

  vppm_demod #(.SYM_LEN(SYM)) dut (
    .clk(clk), .rst(rst), .clk_smp(clk_smp), .rx_in(rx_in),
    .data_out(data_out), .data_valid(data_valid), .duty(duty),
    .locked(locked), .sym_err(sym_err), .lost(lost)
  );

  always #5 clk = ~clk;

  bit smp_q[$];
  int per_q[$];
  logic [7:0] e_data[], e_duty[];
  bit e_lock[], e_valid[], e_err[], e_lost[];

  logic [7:0] x_data = 8'd0, x_duty = 8'd0;
  bit x_lock = 0, x_valid = 0, x_err = 0, x_lost = 0;
  int checks = 0, errors = 0;
  int n_valid = 0, n_err = 0, n_lost = 0;
  bit chk_en = 0;
  int pos = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Stream construction
  function automatic void add_smp(bit v, int p);
    smp_q.push_back(v);
    per_q.push_back(p);
  endfunction
  function automatic void add_zeros(int n, int p);
    for (int k = 0; k < n; k++) add_smp(1'b0, p);
  endfunction
  function automatic void add_sym(int lo, int hi, int p);
    for (int k = 0; k < SYM; k++) add_smp(k >= lo && k <= hi, p);
  endfunction
  function automatic void add_bit(bit v, int w, int p);
    if (v) add_sym(SYM - w, SYM - 1, p);
    else add_sym(0, w - 1, p);
  endfunction
  function automatic void add_byte(logic [7:0] b, int w, int p);
    for (int k = 7; k >= 0; k--) add_bit(b[k], w, p);
  endfunction

  function automatic void snap(int k, bit lk, logic [7:0] d, logic [7:0] du, bit v, bit er, bit ls);
    e_lock[k] = lk; e_data[k] = d; e_duty[k] = du;
    e_valid[k] = v; e_err[k] = er; e_lost[k] = ls;
  endfunction

  // Model: find a rising sample edge, then judge whole SYM-sample windows by their half counts.
  function automatic void scan(int lo, int hi);
    int i; bit prev; bit first; bit done;
    logic [7:0] data; logic [7:0] duty_m; logic [7:0] t;
    bit bits[$];
    int a; int b; int e; bit v; bit vld;
    i = lo; prev = 0; data = 8'd0; duty_m = 8'd0;
    while (i < hi) begin
      if (smp_q[i] && !prev) begin
        first = 1; done = 0; bits.delete();
        while (!done) begin
          a = 0; b = 0; e = i + SYM - 1;
          for (int j = 0; j < SYM && i + j < hi; j++) begin
            snap(i + j, 1, data, duty_m, 0, 0, 0);
            if (smp_q[i + j]) begin
              if (j < SYM / 2) a++;
              else b++;
            end
          end
          if (e >= hi) begin
            i = hi; done = 1;
          end else if (a + b == 0) begin
            snap(e, 0, data, duty_m, 0, 0, 1);
            prev = 0; i = e + 1; done = 1;
          end else begin
            duty_m = (a + b > 255) ? 8'd255 : 8'(a + b);
            v = (b > a); vld = 0;
            if (first) first = 0;
            else begin
              bits.push_back(v);
              if (bits.size() == 8) begin
                t = 8'd0;
                for (int k = 0; k < 8; k++) t = {t[6:0], bits[k]};
                data = t; vld = 1; bits.delete();
              end
            end
            snap(e, 1, data, duty_m, vld, a == b, 0);
            prev = smp_q[e]; i = e + 1;
          end
        end
      end else begin
        snap(i, 0, data, duty_m, 0, 0, 0);
        prev = smp_q[i]; i++;
      end
    end
  endfunction

  // One clk_smp period per sample; rx glitches while clk_smp is high, after the tick has been taken.
  task automatic drive_sample(int k);
    int h;
    h = per_q[k] / 2;
    rx_in = smp_q[k];
    clk_smp = 1'b0;
    repeat (h) @(negedge clk);
    clk_smp = 1'b1;
    repeat (2) @(negedge clk);
    x_data = e_data[k]; x_duty = e_duty[k]; x_lock = e_lock[k];
    x_valid = e_valid[k]; x_err = e_err[k]; x_lost = e_lost[k];
    @(negedge clk);
    x_valid = 0; x_err = 0; x_lost = 0;
    @(negedge clk);
    rx_in = ~smp_q[k];
    repeat (h - 4) @(negedge clk);
  endtask

  task automatic run_to(int hi);
    while (pos < hi) begin
      drive_sample(pos);
      pos++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("data_out", data_out, x_data);
      chk("duty", duty, x_duty);
      chk("locked", locked, x_lock);
      chk("data_valid", data_valid, x_valid);
      chk("sym_err", sym_err, x_err);
      chk("lost", lost, x_lost);
      if (data_valid) begin
        n_valid++;
        $display("byte 0x%02h duty %0d t=%0t", data_out, duty, $time);
      end
      if (sym_err) n_err++;
      if (lost) n_lost++;
    end
  end

  task automatic check_all_zero(string tag);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_sym_err"}, sym_err, 0);
    chk({tag, "_lost"}, lost, 0);
  endtask

  int m1, m2a, m2b, m2c, m3a, m3b, m4a, m4b, rst_at, m5;
  int msw[3];
  int psw[3] = '{10, 22, 50};

  initial begin
    // Basic 0xA5 frame followed by an all-dark symbol
    add_zeros(4, 10); add_bit(0, 4, 10); add_byte(8'hA5, 4, 10); add_zeros(SYM, 10);
    m1 = smp_q.size();
    // Dimming sweep
    add_bit(0, 2, 10); add_byte(8'h0F, 2, 10); m2a = smp_q.size();
    add_byte(8'h96, 6, 10); m2b = smp_q.size();
    add_byte(8'h3E, 8, 10); add_zeros(SYM, 10); m2c = smp_q.size();
    // Ambiguous third bit
    add_bit(0, 4, 10); add_bit(1, 4, 10); add_bit(0, 4, 10); add_sym(6, 9, 10);
    m3a = smp_q.size();
    add_bit(1, 4, 10); add_bit(1, 4, 10); add_bit(0, 4, 10); add_bit(0, 4, 10); add_bit(1, 4, 10);
    add_zeros(SYM, 10); m3b = smp_q.size();
    // Carrier loss after 5 bits, then a clean frame
    add_bit(0, 4, 10); add_bit(1, 4, 10); add_bit(1, 4, 10); add_bit(0, 4, 10);
    add_bit(1, 4, 10); add_bit(0, 4, 10); add_zeros(SYM, 10); m4a = smp_q.size();
    add_bit(0, 4, 10); add_byte(8'hC3, 4, 10); add_zeros(SYM, 10); m4b = smp_q.size();
    // Three bits plus idx 0-6 of the fourth, then reset
    add_bit(0, 4, 10); add_bit(1, 4, 10); add_bit(1, 4, 10); add_bit(1, 4, 10); add_zeros(7, 10);
    rst_at = smp_q.size();
    add_zeros(4, 10); add_bit(0, 4, 10); add_byte(8'h3C, 4, 10); add_zeros(SYM, 10);
    m5 = smp_q.size();
    for (int s = 0; s < 3; s++) begin
      add_zeros(4, psw[s]); add_bit(0, 4, psw[s]); add_byte(8'h6D, 4, psw[s]); add_zeros(SYM, psw[s]);
      msw[s] = smp_q.size();
    end

    e_data = new[smp_q.size()]; e_duty = new[smp_q.size()]; e_lock = new[smp_q.size()];
    e_valid = new[smp_q.size()]; e_err = new[smp_q.size()]; e_lost = new[smp_q.size()];
    scan(0, rst_at);
    scan(rst_at, smp_q.size());

    chk_en = 1;
    repeat (2) @(negedge clk);
    check_all_zero("init_rst");
    rst = 0;
    repeat (2) @(negedge clk);

    run_to(m1);
    chk("a5_data", data_out, 8'hA5); chk("a5_duty", duty, 4);
    chk("a5_unlocked", locked, 0); chk("a5_nvalid", n_valid, 1); chk("a5_nlost", n_lost, 1);

    run_to(m2a);
    chk("dim2_data", data_out, 8'h0F); chk("dim2_duty", duty, 2);
    run_to(m2b);
    chk("dim6_data", data_out, 8'h96); chk("dim6_duty", duty, 6);
    run_to(m2c);
    chk("dim8_data", data_out, 8'h3E); chk("dim8_duty", duty, 8);
    chk("dim_nvalid", n_valid, 4); chk("dim_nlost", n_lost, 2);

    run_to(m3a);
    chk("amb_locked", locked, 1); chk("amb_nerr", n_err, 1); chk("amb_duty", duty, 4);
    run_to(m3b);
    chk("amb_data", data_out, 8'h99); chk("amb_nvalid", n_valid, 5); chk("amb_nlost", n_lost, 3);

    run_to(m4a);
    chk("loss_nlost", n_lost, 4); chk("loss_nvalid", n_valid, 5);
    chk("loss_data", data_out, 8'h99); chk("loss_locked", locked, 0);
    run_to(m4b);
    chk("relock_data", data_out, 8'hC3); chk("relock_nvalid", n_valid, 6);

    run_to(rst_at);
    chk("prerst_locked", locked, 1);
    clk_smp = 0; rx_in = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    x_data = 0; x_duty = 0; x_lock = 0; x_valid = 0; x_err = 0; x_lost = 0;
    #1;
    check_all_zero("mid_rst");
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("postrst_nvalid", n_valid, 6);

    run_to(m5);
    chk("3c_data", data_out, 8'h3C); chk("3c_nvalid", n_valid, 7);

    for (int s = 0; s < 3; s++) begin
      run_to(msw[s]);
      chk($sformatf("sweep%0d_data", psw[s]), data_out, 8'h6D);
      chk($sformatf("sweep%0d_nvalid", psw[s]), n_valid, 8 + s);
    end
    chk("final_nerr", n_err, 1);
    chk("final_nlost", n_lost, 9);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
